// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM with variable-latency memory handshake, timeout halt and
// retire counter. Define ILLEGAL_TRAP_EN to trap opcodes with non-zero extension bits.
module multicycle_control #(
   parameter int unsigned OP_W   = 2,
   parameter int unsigned MEM_TO = 15,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             Clk,
   input  logic             Clear,
   input  logic [OP_W-1:0]  op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             IorD,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrc,
   output logic             Branch,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic [1:0]       ALUOp,
   output logic             retire,
   output logic [CNT_W-1:0] instr_count,
   output logic             halted,
   output logic             mem_err,
   output logic             illegal
);

   localparam int unsigned WaitW  = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
   localparam int unsigned ToLast = (MEM_TO > 0) ? MEM_TO - 1 : 0;

   typedef enum logic [3:0] {
      StRst, StFetch, StDecode, StExecR, StWbR, StAddr,
      StMemRd, StWbMem, StMemWr, StBranch, StHalt
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mem_err_q, mem_err_d;
   logic               mem_wait;

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
   assign illegal = illegal_q;
`else
   logic unused_op_ext;
   assign unused_op_ext = |(op >> 2);
   assign illegal       = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Clear) begin
         state_q   <= StRst;
         op_q      <= '0;
         wait_q    <= '0;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         wait_q    <= wait_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      wait_d    = '0;
      cnt_d     = cnt_q;
      mem_err_d = mem_err_q;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      mem_wait  = 1'b0;
      mem_req   = 1'b0;
      IorD      = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegDst    = 1'b0;
      RegWrite  = 1'b0;
      ALUSrc    = 1'b0;
      Branch    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      MemtoReg  = 1'b0;
      ALUOp     = 2'b00;
      retire    = 1'b0;
      halted    = 1'b0;

      case (state_q)
         StRst: state_d = StFetch;
         StFetch: begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = StDecode;
            end else begin
               mem_wait = 1'b1;
            end
         end
         StDecode: begin
            op_d = op[1:0];
            case (op[1:0])
               2'b00:   state_d = StExecR;
               2'b11:   state_d = StBranch;
               default: state_d = StAddr;
            endcase
`ifdef ILLEGAL_TRAP_EN
            if ((op >> 2) != '0) begin
               illegal_d = 1'b1;
               state_d   = StHalt;
            end
`endif
         end
         StExecR: begin
            ALUOp   = 2'b10;
            state_d = StWbR;
         end
         StWbR: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            retire   = 1'b1;
            state_d  = StFetch;
         end
         StAddr: begin
            ALUSrc = 1'b1;
            if (op_q == 2'b01)      state_d = StMemRd;
            else if (op_q == 2'b10) state_d = StMemWr;
            else                    state_d = StFetch;
         end
         StMemRd: begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) state_d = StWbMem;
            else           mem_wait = 1'b1;
         end
         StWbMem: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            retire   = 1'b1;
            state_d  = StFetch;
         end
         StMemWr: begin
            mem_req  = 1'b1;
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = StFetch;
            end else begin
               mem_wait = 1'b1;
            end
         end
         StBranch: begin
            Branch  = 1'b1;
            ALUOp   = 2'b01;
            PCWrite = zero;
            retire  = 1'b1;
            state_d = StFetch;
         end
         StHalt:  halted  = 1'b1;
         default: state_d = StRst;
      endcase

      // A ready in the limit cycle never reaches here, so it beats the timeout.
      if (mem_wait) begin
         if (MEM_TO > 0 && wait_q == WaitW'(ToLast)) begin
            mem_err_d = 1'b1;
            state_d   = StHalt;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end

      if (retire) cnt_d = cnt_q + 1'b1;
   end

   assign instr_count = cnt_q;
   assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (OP_W=3, MEM_TO=4, CNT_W=2); expected per-cycle
// control vectors go through a scoreboard queue. Honours ILLEGAL_TRAP_EN if defined.
module tb_multicycle_control;

   logic       Clk = 1'b0;
   logic       Clear, zero, mem_ready;
   logic [2:0] op;
   logic       mem_req, IorD, IRWrite, PCWrite, RegDst, RegWrite, ALUSrc, Branch;
   logic       MemRead, MemWrite, MemtoReg, retire, halted, mem_err, illegal;
   logic [1:0] ALUOp;
   logic [1:0] instr_count;
   logic [16:0] obs;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [16:0] B_MREQ  = 17'h10000;
   localparam logic [16:0] B_IORD  = 17'h08000;
   localparam logic [16:0] B_IRW   = 17'h04000;
   localparam logic [16:0] B_PCW   = 17'h02000;
   localparam logic [16:0] B_RDST  = 17'h01000;
   localparam logic [16:0] B_RW    = 17'h00800;
   localparam logic [16:0] B_ASRC  = 17'h00400;
   localparam logic [16:0] B_BR    = 17'h00200;
   localparam logic [16:0] B_MRD   = 17'h00100;
   localparam logic [16:0] B_MWR   = 17'h00080;
   localparam logic [16:0] B_M2R   = 17'h00040;
   localparam logic [16:0] B_OPFN  = 17'h00020;
   localparam logic [16:0] B_OPSUB = 17'h00010;
   localparam logic [16:0] B_RET   = 17'h00008;
   localparam logic [16:0] B_HLT   = 17'h00004;
   localparam logic [16:0] B_MERR  = 17'h00002;
   localparam logic [16:0] B_ILL   = 17'h00001;

   localparam logic [16:0] E_NONE   = 17'h0;
   localparam logic [16:0] E_FETCH  = B_MREQ | B_MRD;
   localparam logic [16:0] E_FETCHR = B_MREQ | B_MRD | B_IRW | B_PCW;
   localparam logic [16:0] E_EXECR  = B_OPFN;
   localparam logic [16:0] E_WBR    = B_RW | B_RDST | B_RET;
   localparam logic [16:0] E_ADDR   = B_ASRC;
   localparam logic [16:0] E_MEMRD  = B_MREQ | B_MRD | B_IORD;
   localparam logic [16:0] E_WBMEM  = B_RW | B_M2R | B_RET;
   localparam logic [16:0] E_MEMWR  = B_MREQ | B_MWR | B_IORD;
   localparam logic [16:0] E_BRANCH = B_BR | B_OPSUB | B_RET;

   typedef struct {
      logic [16:0] ctl;
      logic [1:0]  cnt;
      string       tag;
   } exp_t;

   exp_t sb[$];

   multicycle_control #(
      .OP_W   (3),
      .MEM_TO (4),
      .CNT_W  (2)
   ) dut (
      .Clk         (Clk),
      .Clear       (Clear),
      .op          (op),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .IorD        (IorD),
      .IRWrite     (IRWrite),
      .PCWrite     (PCWrite),
      .RegDst      (RegDst),
      .RegWrite    (RegWrite),
      .ALUSrc      (ALUSrc),
      .Branch      (Branch),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemtoReg    (MemtoReg),
      .ALUOp       (ALUOp),
      .retire      (retire),
      .instr_count (instr_count),
      .halted      (halted),
      .mem_err     (mem_err),
      .illegal     (illegal)
   );

   always #5 Clk = ~Clk;

   assign obs = {mem_req, IorD, IRWrite, PCWrite, RegDst, RegWrite, ALUSrc, Branch,
                 MemRead, MemWrite, MemtoReg, ALUOp, retire, halted, mem_err, illegal};

   // One cycle: drive inputs, queue the expectation, check it mid-cycle, advance.
   task automatic step(input logic clr, input logic [2:0] o, input logic z, input logic rdy,
                       input logic [16:0] ctl, input logic [1:0] cnt, input string tag);
      exp_t e;
      Clear     = clr;
      op        = o;
      zero      = z;
      mem_ready = rdy;
      e.ctl = ctl;
      e.cnt = cnt;
      e.tag = tag;
      sb.push_back(e);
      @(negedge Clk);
      e = sb.pop_front();
      n_chk++;
      assert (obs === e.ctl) else begin
         n_fail++;
         $error("FAIL %s ctl: got %h want %h", e.tag, obs, e.ctl);
      end
      n_chk++;
      assert (instr_count === e.cnt) else begin
         n_fail++;
         $error("FAIL %s count: got %0d want %0d", e.tag, instr_count, e.cnt);
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Clear = 1'b1; op = 3'b000; zero = 1'b0; mem_ready = 1'b1;
      @(posedge Clk);
      #1;
      step(1'b1, 3'b000, 1'b0, 1'b1, E_NONE,   2'd0, "clear");
      step(1'b0, 3'b000, 1'b0, 1'b1, E_NONE,   2'd0, "rst");
      // R-type, mem_ready high throughout (ignored outside wait states)
      step(1'b0, 3'b000, 1'b0, 1'b1, E_FETCHR, 2'd0, "r_fetch");
      step(1'b0, 3'b000, 1'b0, 1'b1, E_NONE,   2'd0, "r_decode");
      step(1'b0, 3'b011, 1'b1, 1'b1, E_EXECR,  2'd0, "r_exec");
      step(1'b0, 3'b011, 1'b1, 1'b1, E_WBR,    2'd0, "r_wb");
      // LW with three stall cycles in MEM_RD
      step(1'b0, 3'b000, 1'b0, 1'b1, E_FETCHR, 2'd1, "lw_fetch");
      step(1'b0, 3'b001, 1'b0, 1'b0, E_NONE,   2'd1, "lw_decode");
      step(1'b0, 3'b000, 1'b0, 1'b1, E_ADDR,   2'd1, "lw_addr");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_MEMRD,  2'd1, "lw_mem_w0");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_MEMRD,  2'd1, "lw_mem_w1");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_MEMRD,  2'd1, "lw_mem_w2");
      step(1'b0, 3'b000, 1'b0, 1'b1, E_MEMRD,  2'd1, "lw_mem_rdy");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_WBMEM,  2'd1, "lw_wb");
      // SW with one stall cycle
      step(1'b0, 3'b000, 1'b0, 1'b1, E_FETCHR, 2'd2, "sw_fetch");
      step(1'b0, 3'b010, 1'b0, 1'b1, E_NONE,   2'd2, "sw_decode");
      step(1'b0, 3'b000, 1'b0, 1'b1, E_ADDR,   2'd2, "sw_addr");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_MEMWR,  2'd2, "sw_mem_w0");
      step(1'b0, 3'b000, 1'b0, 1'b1, E_MEMWR | B_RET, 2'd2, "sw_mem_rdy");
      // BEQ taken, then not taken; counter wraps 3 -> 0 -> 1
      step(1'b0, 3'b000, 1'b0, 1'b1, E_FETCHR, 2'd3, "beq1_fetch");
      step(1'b0, 3'b011, 1'b0, 1'b1, E_NONE,   2'd3, "beq1_decode");
      step(1'b0, 3'b000, 1'b1, 1'b1, E_BRANCH | B_PCW, 2'd3, "beq1_branch");
      step(1'b0, 3'b000, 1'b1, 1'b1, E_FETCHR, 2'd0, "beq2_fetch");
      step(1'b0, 3'b011, 1'b1, 1'b1, E_NONE,   2'd0, "beq2_decode");
      step(1'b0, 3'b000, 1'b0, 1'b1, E_BRANCH, 2'd0, "beq2_branch");
      // Extension opcode 101
      step(1'b0, 3'b000, 1'b0, 1'b1, E_FETCHR, 2'd1, "ext_fetch");
      step(1'b0, 3'b101, 1'b0, 1'b1, E_NONE,   2'd1, "ext_decode");
`ifdef ILLEGAL_TRAP_EN
      step(1'b0, 3'b000, 1'b0, 1'b1, B_HLT | B_ILL, 2'd1, "ext_halt0");
      step(1'b0, 3'b000, 1'b0, 1'b1, B_HLT | B_ILL, 2'd1, "ext_halt1");
      step(1'b1, 3'b000, 1'b0, 1'b0, B_HLT | B_ILL, 2'd1, "ext_clear");
`else
      step(1'b0, 3'b000, 1'b0, 1'b1, E_ADDR,   2'd1, "ext_addr");
      step(1'b0, 3'b000, 1'b0, 1'b1, E_MEMRD,  2'd1, "ext_mem");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_WBMEM,  2'd1, "ext_wb");
      step(1'b1, 3'b000, 1'b0, 1'b0, E_FETCH,  2'd2, "ext_clear");
`endif
      step(1'b0, 3'b000, 1'b0, 1'b0, E_NONE,   2'd0, "rst2");
      // Timeout: four waiting FETCH cycles, then HALT ignoring mem_ready
      step(1'b0, 3'b000, 1'b0, 1'b0, E_FETCH,  2'd0, "to_w0");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_FETCH,  2'd0, "to_w1");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_FETCH,  2'd0, "to_w2");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_FETCH,  2'd0, "to_w3");
      step(1'b0, 3'b000, 1'b0, 1'b1, B_HLT | B_MERR, 2'd0, "to_halt0");
      step(1'b0, 3'b000, 1'b0, 1'b1, B_HLT | B_MERR, 2'd0, "to_halt1");
      step(1'b1, 3'b000, 1'b0, 1'b0, B_HLT | B_MERR, 2'd0, "to_clear");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_NONE,   2'd0, "rst3");
      // mem_ready in the limit cycle wins over the timeout
      step(1'b0, 3'b000, 1'b0, 1'b0, E_FETCH,  2'd0, "lim_w0");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_FETCH,  2'd0, "lim_w1");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_FETCH,  2'd0, "lim_w2");
      step(1'b0, 3'b000, 1'b0, 1'b1, E_FETCHR, 2'd0, "lim_rdy");
      step(1'b0, 3'b011, 1'b0, 1'b0, E_NONE,   2'd0, "lim_decode");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_BRANCH, 2'd0, "lim_branch");
      step(1'b0, 3'b000, 1'b0, 1'b0, E_FETCH,  2'd1, "lim_fetch");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
